// File: rtl/manchester_framer.sv
// Wraps each escaped payload packet into a line frame: preamble, start word, payload, idle gap.
// Optional frame/byte statistics ports are enabled by defining MANCHESTER_FRAMER_STATS_EN.
module manchester_framer #(
    parameter int unsigned             DATA_WIDTH    = 8,
    parameter int unsigned             PREAMBLE_LEN  = 4,
    parameter logic [DATA_WIDTH-1:0]   PREAMBLE_BYTE = 8'h55,
    parameter logic [DATA_WIDTH-1:0]   START_WORD    = 8'hD5,
    parameter int unsigned             GAP_CYCLES    = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy
`ifdef MANCHESTER_FRAMER_STATS_EN
    ,
    output logic [15:0]           frame_count,
    output logic [31:0]           byte_count
`endif
);

    localparam int unsigned PRE_N = (PREAMBLE_LEN > 0) ? PREAMBLE_LEN : 1;
    localparam int unsigned PRE_W = $clog2(PRE_N) + 1;
    localparam int unsigned GAP_N = (GAP_CYCLES > 0) ? GAP_CYCLES : 1;
    localparam int unsigned GAP_W = $clog2(GAP_N) + 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_N - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SOF,
        S_PAYLOAD,
        S_DRAIN,
        S_GAP
    } state_t;

    state_t                state_q, state_d;
    logic [PRE_W-1:0]      pre_cnt_q, pre_cnt_d;
    logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_valid_q, m_valid_d;
    logic                  m_last_q, m_last_d;
    logic                  load;
    logic                  s_ready;

    assign load    = !m_valid_q || m_axis_tready;
    assign s_ready = aresetn && (state_q == S_PAYLOAD) && load;

    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        gap_cnt_d = gap_cnt_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;

        // A taken beat empties the register unless a state below reloads it.
        if (m_valid_q && m_axis_tready) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (s_axis_tvalid) begin
                    state_d = (PREAMBLE_LEN > 0) ? S_PREAMBLE : S_SOF;
                end
            end
            S_PREAMBLE: begin
                if (load) begin
                    m_data_d  = PREAMBLE_BYTE;
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b0;
                    if (pre_cnt_q == PRE_LAST) begin
                        pre_cnt_d = '0;
                        state_d   = S_SOF;
                    end else begin
                        pre_cnt_d = pre_cnt_q + 1'b1;
                    end
                end
            end
            S_SOF: begin
                if (load) begin
                    m_data_d  = START_WORD;
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b0;
                    state_d   = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (s_ready && s_axis_tvalid) begin
                    m_data_d  = s_axis_tdata;
                    m_valid_d = 1'b1;
                    m_last_d  = s_axis_tlast;
                    if (s_axis_tlast) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (m_valid_q && m_axis_tready) begin
                    state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= S_IDLE;
            pre_cnt_q <= '0;
            gap_cnt_q <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
        end
    end

    assign s_axis_tready = s_ready;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;
    assign busy          = (state_q != S_IDLE);

`ifdef MANCHESTER_FRAMER_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [31:0] byte_cnt_q;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            frame_cnt_q <= '0;
            byte_cnt_q  <= '0;
        end else if (m_valid_q && m_axis_tready) begin
            byte_cnt_q <= byte_cnt_q + 1'b1;
            if (m_last_q) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

    assign frame_count = frame_cnt_q;
    assign byte_count  = byte_cnt_q;
`endif

endmodule

// File: tb/tb_manchester_framer.sv
// Self-checking bench for manchester_framer: random payloads checked against a frame-building model.
module tb_manchester_framer;

    localparam int unsigned PL   = 4;
    localparam int unsigned GAP  = 8;
    localparam int unsigned NONE = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       arst;
    logic [7:0] a_sd, a_md, b_sd, b_md;
    logic       a_sv, a_sl, a_sr, a_mv, a_mr, a_ml, a_busy;
    logic       b_sv, b_sl, b_sr, b_mv, b_mr, b_ml, b_busy;
`ifdef MANCHESTER_FRAMER_STATS_EN
    logic [15:0] a_fc, b_fc;
    logic [31:0] a_bc, b_bc;
`endif

    manchester_framer #(.PREAMBLE_LEN(PL), .GAP_CYCLES(GAP)) dut_a (
        .aclk(clk), .aresetn(arst),
        .s_axis_tdata(a_sd), .s_axis_tvalid(a_sv), .s_axis_tready(a_sr), .s_axis_tlast(a_sl),
        .m_axis_tdata(a_md), .m_axis_tvalid(a_mv), .m_axis_tready(a_mr), .m_axis_tlast(a_ml),
        .busy(a_busy)
`ifdef MANCHESTER_FRAMER_STATS_EN
        , .frame_count(a_fc), .byte_count(a_bc)
`endif
    );

    manchester_framer #(.PREAMBLE_LEN(0), .GAP_CYCLES(0)) dut_b (
        .aclk(clk), .aresetn(arst),
        .s_axis_tdata(b_sd), .s_axis_tvalid(b_sv), .s_axis_tready(b_sr), .s_axis_tlast(b_sl),
        .m_axis_tdata(b_md), .m_axis_tvalid(b_mv), .m_axis_tready(b_mr), .m_axis_tlast(b_ml),
        .busy(b_busy)
`ifdef MANCHESTER_FRAMER_STATS_EN
        , .frame_count(b_fc), .byte_count(b_bc)
`endif
    );

    int unsigned checks = 0;
    int unsigned passed = 0;

    logic [8:0] a_rx[$];
    logic [8:0] b_rx[$];
    logic [8:0] exp_q[$];
    logic [7:0] a_tx[$];

    int unsigned lat = 0, holes = 0, post_busy = 0, post_valid = 0, stab_err = 0;
    int unsigned b_low = 0, b_frames = 0;
    bit          rand_ready = 1'b0;
    bit          in_frame = 1'b0, after_last = 1'b0, prev_stall = 1'b0, b_between = 1'b0;
    logic [7:0]  prev_d = '0;
    logic        prev_l = 1'b0;

    // Sink ready for dut_a changes just after each rising edge.
    initial begin
        a_mr = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            a_mr = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Observe dut_a at the falling edge; valid && ready here means a handshake at the next rise.
    initial begin
        forever begin
            @(negedge clk);
            if (!arst) begin
                in_frame   = 1'b0;
                after_last = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && (a_mv !== 1'b1 || a_md !== prev_d || a_ml !== prev_l)) stab_err++;
                prev_stall = a_mv && !a_mr;
                prev_d     = a_md;
                prev_l     = a_ml;
                if (!in_frame && !after_last && a_sv && !a_mv) lat++;
                if (after_last) begin
                    if (a_busy) post_busy++;
                    if (a_mv) post_valid++;
                    if (!a_busy) after_last = 1'b0;
                end
                if (in_frame && !a_mv) holes++;
                if (a_mv) in_frame = 1'b1;
                if (a_mv && a_mr) begin
                    a_rx.push_back({a_ml, a_md});
                    if (a_ml) begin
                        in_frame   = 1'b0;
                        after_last = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (arst) begin
                if (b_between && !b_mv) b_low++;
                if (b_mv) b_between = 1'b0;
                if (b_mv && b_mr) begin
                    b_rx.push_back({b_ml, b_md});
                    if (b_ml) begin
                        b_frames++;
                        if (b_frames == 1) b_between = 1'b1;
                    end
                end
            end
        end
    end

    // Reference model: a frame is the preamble run, the start word, then the payload with tlast on its final byte.
    function automatic void build_frame(input int unsigned pre_len);
        exp_q.delete();
        for (int unsigned i = 0; i < pre_len; i++) exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'hD5});
        for (int unsigned k = 0; k < a_tx.size(); k++)
            exp_q.push_back({(k == a_tx.size() - 1) ? 1'b1 : 1'b0, a_tx[k]});
    endfunction

    function automatic logic [7:0] rand_payload_byte();
        logic [7:0] v;
        v = 8'($urandom_range(0, 255));
        if (v == 8'hD5) v = 8'hD4;
        return v;
    endfunction

    task automatic fill_tx(input int unsigned n);
        a_tx.delete();
        for (int unsigned i = 0; i < n; i++) a_tx.push_back(rand_payload_byte());
    endtask

    task automatic a_send(input int unsigned stall_after, input int unsigned stall_len,
                          input int unsigned stop_at);
        int unsigned n;
        int unsigned w;
        n = a_tx.size();
        for (int unsigned i = 0; i < n; i++) begin
            if (i == stop_at) return;
            if (i == stall_after && stall_len > 0) begin
                a_sv = 1'b0;
                repeat (stall_len) @(posedge clk);
                #1;
            end
            a_sd = a_tx[i];
            a_sl = (i == n - 1);
            a_sv = 1'b1;
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!a_sr && w < 2000);
            if (!a_sr) begin
                checks++;
                $display("FAIL a_send_timeout byte=%0d s_axis_tready=%b required 1", i, a_sr);
                a_sv = 1'b0;
                a_sl = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        a_sv = 1'b0;
        a_sl = 1'b0;
    endtask

    task automatic wait_a_idle();
        int unsigned w;
        w = 0;
        repeat (2) @(negedge clk);
        while (a_busy && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (a_busy) begin
            checks++;
            $display("FAIL a_idle_timeout busy=%b required 0", a_busy);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        arst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (a_mv !== 1'b0) $display("FAIL rst_a_tvalid got %b want 0", a_mv); else passed++;
        checks++; if (a_ml !== 1'b0) $display("FAIL rst_a_tlast got %b want 0", a_ml); else passed++;
        checks++; if (a_md !== 8'h00) $display("FAIL rst_a_tdata got %h want 00", a_md); else passed++;
        checks++; if (a_busy !== 1'b0) $display("FAIL rst_a_busy got %b want 0", a_busy); else passed++;
        checks++; if (a_sr !== 1'b0) $display("FAIL rst_a_tready got %b want 0", a_sr); else passed++;
        checks++; if (b_mv !== 1'b0) $display("FAIL rst_b_tvalid got %b want 0", b_mv); else passed++;
        checks++; if (b_busy !== 1'b0) $display("FAIL rst_b_busy got %b want 0", b_busy); else passed++;
`ifdef MANCHESTER_FRAMER_STATS_EN
        checks++; if (a_fc !== 16'd0) $display("FAIL rst_frame_count got %0d want 0", a_fc); else passed++;
        checks++; if (a_bc !== 32'd0) $display("FAIL rst_byte_count got %0d want 0", a_bc); else passed++;
`endif
        @(posedge clk);
        #1;
        arst = 1'b1;
    endtask

    task automatic test_basic();
        a_rx.delete();
        lat = 0; holes = 0; post_busy = 0; post_valid = 0;
        a_tx.delete();
        a_tx.push_back(8'h01); a_tx.push_back(8'h02); a_tx.push_back(8'h03);
        a_send(NONE, 0, NONE);
        wait_a_idle();
        build_frame(PL);
        checks++; if (a_rx.size() != exp_q.size()) $display("FAIL basic_len got %0d want %0d", a_rx.size(), exp_q.size()); else passed++;
        for (int unsigned k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (k >= a_rx.size() || a_rx[k] !== exp_q[k])
                $display("FAIL basic_beat%0d got %h want %h", k, (k < a_rx.size()) ? a_rx[k] : 9'h1FF, exp_q[k]);
            else passed++;
        end
        checks++; if (lat != 2) $display("FAIL basic_latency got %0d want 2", lat); else passed++;
        checks++; if (holes != 0) $display("FAIL basic_holes got %0d want 0", holes); else passed++;
        checks++; if (post_busy != GAP) $display("FAIL basic_gap_busy got %0d want %0d", post_busy, GAP); else passed++;
        checks++; if (post_valid != 0) $display("FAIL basic_gap_valid got %0d want 0", post_valid); else passed++;
    endtask

    task automatic test_no_preamble();
        logic [7:0] pay[2];
        int unsigned w;
        pay[0] = 8'hAA;
        pay[1] = 8'hBB;
        b_rx.delete();
        b_low = 0; b_frames = 0;
        exp_q.delete();
        for (int unsigned p = 0; p < 2; p++) begin
            exp_q.push_back({1'b0, 8'hD5});
            exp_q.push_back({1'b1, pay[p]});
        end
        for (int unsigned p = 0; p < 2; p++) begin
            b_sd = pay[p];
            b_sl = 1'b1;
            b_sv = 1'b1;
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!b_sr && w < 2000);
            if (!b_sr) begin
                checks++;
                $display("FAIL b_send_timeout byte=%0d s_axis_tready=%b required 1", p, b_sr);
            end
            @(posedge clk);
            #1;
        end
        b_sv = 1'b0;
        b_sl = 1'b0;
        w = 0;
        repeat (2) @(negedge clk);
        while (b_busy && w < 2000) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        checks++; if (b_rx.size() != exp_q.size()) $display("FAIL nopre_len got %0d want %0d", b_rx.size(), exp_q.size()); else passed++;
        for (int unsigned k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (k >= b_rx.size() || b_rx[k] !== exp_q[k])
                $display("FAIL nopre_beat%0d got %h want %h", k, (k < b_rx.size()) ? b_rx[k] : 9'h1FF, exp_q[k]);
            else passed++;
        end
        checks++; if (b_low > 2) $display("FAIL nopre_idle got %0d want at most 2", b_low); else passed++;
        checks++; if (b_busy !== 1'b0) $display("FAIL nopre_busy got %b want 0", b_busy); else passed++;
    endtask

    task automatic test_backpressure();
        a_rx.delete();
        stab_err = 0;
        fill_tx(16);
        rand_ready = 1'b1;
        a_send(NONE, 0, NONE);
        wait_a_idle();
        rand_ready = 1'b0;
        @(negedge clk);
        build_frame(PL);
        checks++; if (a_rx.size() != exp_q.size()) $display("FAIL bp_len got %0d want %0d", a_rx.size(), exp_q.size()); else passed++;
        for (int unsigned k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (k >= a_rx.size() || a_rx[k] !== exp_q[k])
                $display("FAIL bp_beat%0d got %h want %h", k, (k < a_rx.size()) ? a_rx[k] : 9'h1FF, exp_q[k]);
            else passed++;
        end
        checks++; if (stab_err != 0) $display("FAIL bp_stable got %0d changes want 0", stab_err); else passed++;
    endtask

    task automatic test_input_stall();
        a_rx.delete();
        holes = 0;
        fill_tx(8);
        a_send(3, 5, NONE);
        wait_a_idle();
        build_frame(PL);
        checks++; if (a_rx.size() != exp_q.size()) $display("FAIL stall_len got %0d want %0d", a_rx.size(), exp_q.size()); else passed++;
        for (int unsigned k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (k >= a_rx.size() || a_rx[k] !== exp_q[k])
                $display("FAIL stall_beat%0d got %h want %h", k, (k < a_rx.size()) ? a_rx[k] : 9'h1FF, exp_q[k]);
            else passed++;
        end
        checks++; if (holes != 5) $display("FAIL stall_holes got %0d want 5", holes); else passed++;
    endtask

    task automatic test_mid_reset();
        fill_tx(6);
        a_rx.delete();
        a_send(NONE, 0, 2);
        a_sd = a_tx[2];
        a_sl = 1'b0;
        a_sv = 1'b1;
        arst = 1'b0;
        @(posedge clk);
        #1;
        arst = 1'b1;
        a_sv = 1'b0;
        @(negedge clk);
        checks++; if (a_mv !== 1'b0) $display("FAIL mrst_tvalid got %b want 0", a_mv); else passed++;
        checks++; if (a_busy !== 1'b0) $display("FAIL mrst_busy got %b want 0", a_busy); else passed++;
        checks++; if (a_ml !== 1'b0) $display("FAIL mrst_tlast got %b want 0", a_ml); else passed++;
        checks++; if (a_sr !== 1'b0) $display("FAIL mrst_tready got %b want 0", a_sr); else passed++;
        repeat (3) @(negedge clk);
        checks++; if (a_mv !== 1'b0 || a_busy !== 1'b0) $display("FAIL mrst_quiet got valid=%b busy=%b want 0 0", a_mv, a_busy); else passed++;
        a_rx.delete();
        @(posedge clk);
        #1;
        fill_tx(3);
        a_send(NONE, 0, NONE);
        wait_a_idle();
        build_frame(PL);
        checks++; if (a_rx.size() != exp_q.size()) $display("FAIL mrst_len got %0d want %0d", a_rx.size(), exp_q.size()); else passed++;
        for (int unsigned k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (k >= a_rx.size() || a_rx[k] !== exp_q[k])
                $display("FAIL mrst_beat%0d got %h want %h", k, (k < a_rx.size()) ? a_rx[k] : 9'h1FF, exp_q[k]);
            else passed++;
        end
    endtask

`ifdef MANCHESTER_FRAMER_STATS_EN
    task automatic test_stats();
        int unsigned sizes[3];
        int unsigned exp_bytes;
        sizes[0] = 3; sizes[1] = 1; sizes[2] = 10;
        arst = 1'b0;
        @(posedge clk);
        #1;
        arst = 1'b1;
        exp_bytes = 0;
        for (int unsigned f = 0; f < 3; f++) begin
            fill_tx(sizes[f]);
            exp_bytes += PL + 1 + sizes[f];
            a_send(NONE, 0, NONE);
            wait_a_idle();
            @(posedge clk);
            #1;
        end
        checks++; if (a_fc !== 16'd3) $display("FAIL stats_frames got %0d want 3", a_fc); else passed++;
        checks++; if (a_bc !== exp_bytes) $display("FAIL stats_bytes got %0d want %0d", a_bc, exp_bytes); else passed++;
    endtask
`endif

    initial begin
        arst = 1'b0;
        a_sd = '0; a_sv = 1'b0; a_sl = 1'b0;
        b_sd = '0; b_sv = 1'b0; b_sl = 1'b0; b_mr = 1'b1;
        test_reset();
        test_basic();
        test_no_preamble();
        test_backpressure();
        test_input_stall();
        test_mid_reset();
`ifdef MANCHESTER_FRAMER_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/manchester_framer.md
Name: manchester_framer

Overview:
- Downstream neighbour of the byte-escape stage on the Manchester TX path.
- Takes the escaped payload AXI-Stream and wraps each packet into a line frame: PREAMBLE_LEN preamble bytes, one START_WORD byte, the payload bytes unchanged, then an enforced idle gap.
- Output feeds the byte serializer / Manchester encoder.
- Payload bytes never equal START_WORD because the upstream stage escapes them, so the framer does not inspect payload content.

Parameters:
- DATA_WIDTH, 8: byte width of both streams.
- PREAMBLE_LEN, 4: number of preamble bytes per frame; 0 allowed (no preamble).
- PREAMBLE_BYTE, 8'h55: preamble symbol.
- START_WORD, 8'hD5: start-of-frame delimiter; must match the escaper's value.
- GAP_CYCLES, 8: clocks with m_axis_tvalid low after a frame's last beat is accepted; 0 allowed.

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- s_axis_tdata  in  DATA_WIDTH  escaped payload byte
- s_axis_tvalid  in  1  payload valid
- s_axis_tready  out  1  payload ready
- s_axis_tlast  in  1  last payload byte of packet
- m_axis_tdata  out  DATA_WIDTH  framed byte to serializer
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  serializer ready
- m_axis_tlast  out  1  last byte of frame
- busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: single clock aclk. Reset is synchronous and active-low on aresetn, sampled on the aclk rising edge.
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, state=IDLE, all counters=0. s_axis_tready is 0 while reset is held.
- Reset mid-frame: the frame is abandoned immediately. No tlast is emitted and no gap is enforced.
- Output register: m_axis_tdata, m_axis_tvalid and m_axis_tlast are registered. The output register loads a new beat when it is empty or its current beat is accepted (!m_axis_tvalid || m_axis_tready).
- Input handshake: s_axis_tready = (state==PAYLOAD) && (!m_axis_tvalid || m_axis_tready). It is combinational from state and m_axis_tready only.
- FSM states and transitions:
  - IDLE: waits for s_axis_tvalid=1; the payload byte is not consumed. Goes to PREAMBLE if PREAMBLE_LEN>0, else SOF. busy goes high from the next cycle.
  - PREAMBLE: loads PREAMBLE_BYTE with tlast=0 into the output register PREAMBLE_LEN times, counted on loads. After the final load, goes to SOF.
  - SOF: loads START_WORD with tlast=0 once, then goes to PAYLOAD.
  - PAYLOAD: each s_axis handshake loads s_axis_tdata and s_axis_tlast into the output register.
    - If s_axis_tvalid drops, the output goes invalid once the current beat is taken; the FSM stays in PAYLOAD. There is no padding and no abort.
    - When a beat with s_axis_tlast=1 is accepted on s_axis, goes to DRAIN.
  - DRAIN: waits until the tlast beat is accepted on m_axis. Then goes to GAP if GAP_CYCLES>0, else IDLE.
  - GAP: m_axis_tvalid=0 for exactly GAP_CYCLES clocks, then goes to IDLE. Input held off (s_axis_tready=0).
- Throughput: with m_axis_tready held high, bytes leave back-to-back, one per clock.
- Latency: the first preamble byte is valid 2 clocks after s_axis_tvalid rises in IDLE. Total frame length on m_axis = PREAMBLE_LEN + 1 + payload beats.
- Backpressure: m_axis_tready low holds tdata/tvalid/tlast stable. Counters do not advance.
- Single-byte payload with tlast=1: framed normally, with tlast on that byte.
- Back-to-back packets: the second frame's first preamble byte leaves no earlier than GAP_CYCLES+1 clocks after the first frame's tlast handshake.
- Counters: each sized $clog2(max(N,1))+1 bits. There is no wrap-around within a frame.

Optional Feature:
- Macro: MANCHESTER_FRAMER_STATS_EN.
- When defined:
  - Adds output ports frame_count [15:0] and byte_count [31:0], both reset to 0.
  - frame_count increments on each m_axis tlast handshake.
  - byte_count increments on every m_axis handshake, preamble and SOF bytes included.
  - Both counters wrap modulo 2^width.
- When not defined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Defaults, m_axis_tready=1, payload 0x01,0x02,0x03 (tlast on 0x03) -> m_axis carries 55,55,55,55,D5,01,02,03 on consecutive clocks, tlast only on 03. Then tvalid stays low for 8 clocks. busy falls after the gap.
- PREAMBLE_LEN=0, GAP_CYCLES=0, two 1-byte packets 0xAA and 0xBB back-to-back -> D5,AA(tlast),D5,BB(tlast) with no idle cycles beyond the IDLE detection cycle.
- Random m_axis_tready (50%) on a 16-byte payload -> output sequence identical to the ready=1 run. No beat changes while valid && !ready.
- s_axis_tvalid gap of 5 clocks mid-payload -> m_axis_tvalid low for 5 clocks, no extra bytes, frame completes correctly.
- aresetn asserted for 1 clock during payload byte 2 -> next cycle m_axis_tvalid=0, busy=0, state IDLE. A following packet is framed from the preamble with no residual bytes.
- With MANCHESTER_FRAMER_STATS_EN, three frames of 3, 1, 10 payload bytes at defaults -> frame_count=3, byte_count=29.
